// File: rtl/jtag_scan_sequencer_if.sv
// Request/response bus between a scan client and jtag_scan_sequencer.
interface jtag_scan_sequencer_if;
    logic        start;
    logic        scan_ir;
    logic [5:0]  len;
    logic [31:0] tdi_data;
    logic [3:0]  idle_cnt;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] tdo_data;

    modport master (
        output start, scan_ir, len, tdi_data, idle_cnt,
        input  busy, done, err, tdo_data
    );

    modport slave (
        input  start, scan_ir, len, tdi_data, idle_cnt,
        output busy, done, err, tdo_data
    );
endinterface

// File: rtl/jtag_scan_sequencer.sv
// JTAG master that walks a target TAP through one IR or DR scan per request.
// Optional macro JTAG_SEQ_IDLE_PAD_EN adds idle_cnt extra Run-Test/Idle cycles after each scan.
module jtag_scan_sequencer (
    input  logic                 TCK,
    input  logic                 TRST,
    input  logic                 tdo,
    output logic                 TMS,
    output logic                 TDI,
    jtag_scan_sequencer_if.slave bus
);
    typedef enum logic [3:0] {
        StSync, StIdle, StSelDr, StSelIr, StCapture,
        StShift, StExit1, StUpdate, StPad, StFinish
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [4:0]  last_q, last_d;
    logic        ir_q, ir_d;
    logic        err_q, err_d;
    logic        tms_q, tms_d;
    logic        tdi_q, tdi_d;
    logic [31:0] data_q, data_d;
    logic [31:0] tdo_data_q, tdo_data_d;
`ifdef JTAG_SEQ_IDLE_PAD_EN
    logic [3:0]  pad_q, pad_d;
`else
    logic        unused_idle_cnt;
    assign unused_idle_cnt = ^bus.idle_cnt;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        ir_d       = ir_q;
        err_d      = err_q;
        data_d     = data_q;
        tdo_data_d = tdo_data_q;
`ifdef JTAG_SEQ_IDLE_PAD_EN
        pad_d      = pad_q;
`endif
        case (state_q)
            StSync: begin
                if (cnt_q == 5'd5) begin
                    state_d = StIdle;
                    cnt_d   = 5'd0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            StIdle, StFinish: begin
                if (state_q == StFinish) state_d = StIdle;
                if (bus.start) begin
                    if (bus.len == 6'd0) begin
                        state_d = StFinish;
                        err_d   = 1'b1;
                    end else begin
                        state_d    = StSelDr;
                        err_d      = 1'b0;
                        ir_d       = bus.scan_ir;
                        data_d     = bus.tdi_data;
                        last_d     = (bus.len > 6'd32) ? 5'd31 : 5'(bus.len - 6'd1);
                        tdo_data_d = '0;
                        cnt_d      = 5'd0;
`ifdef JTAG_SEQ_IDLE_PAD_EN
                        pad_d      = bus.idle_cnt;
`endif
                    end
                end
            end
            StSelDr: state_d = ir_q ? StSelIr : StCapture;
            StSelIr: state_d = StCapture;
            // Two TMS=0 cycles: Select->Capture, then Capture->Shift.
            StCapture: begin
                if (cnt_q == 5'd1) begin
                    cnt_d   = 5'd0;
                    state_d = (last_q == 5'd0) ? StExit1 : StShift;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            StShift: begin
                tdo_data_d[cnt_q] = tdo;
                cnt_d             = cnt_q + 5'd1;
                if (cnt_q + 5'd1 == last_q) state_d = StExit1;
            end
            // Final bit shifts while TMS=1 moves the TAP into Exit1.
            StExit1: begin
                tdo_data_d[cnt_q] = tdo;
                state_d           = StUpdate;
            end
            StUpdate: state_d = StPad;
            StPad: begin
`ifdef JTAG_SEQ_IDLE_PAD_EN
                if (pad_q == 4'd0) state_d = StFinish;
                else pad_d = pad_q - 4'd1;
`else
                state_d = StFinish;
`endif
            end
            default: state_d = StSync;
        endcase

        // Pin values are registered, so decode them from the next state.
        case (state_d)
            StSync:                               tms_d = (cnt_d != 5'd5);
            StSelDr, StSelIr, StExit1, StUpdate:  tms_d = 1'b1;
            default:                              tms_d = 1'b0;
        endcase
        tdi_d = (state_d == StShift || state_d == StExit1) ? data_d[cnt_d] : 1'b0;
    end

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            state_q    <= StSync;
            cnt_q      <= 5'd0;
            last_q     <= 5'd0;
            ir_q       <= 1'b0;
            err_q      <= 1'b0;
            tms_q      <= 1'b1;
            tdi_q      <= 1'b0;
            data_q     <= '0;
            tdo_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            ir_q       <= ir_d;
            err_q      <= err_d;
            tms_q      <= tms_d;
            tdi_q      <= tdi_d;
            data_q     <= data_d;
            tdo_data_q <= tdo_data_d;
        end
    end

`ifdef JTAG_SEQ_IDLE_PAD_EN
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) pad_q <= 4'd0;
        else      pad_q <= pad_d;
    end
`endif

    assign TMS          = tms_q;
    assign TDI          = tdi_q;
    assign bus.busy     = !(state_q == StIdle || state_q == StFinish);
    assign bus.done     = (state_q == StFinish);
    assign bus.err      = (state_q == StFinish) && err_q;
    assign bus.tdo_data = tdo_data_q;
endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// Bench for jtag_scan_sequencer: reference TAP model on the pins, scoreboard of expected scans.
module tb_jtag_scan_sequencer;
    logic TCK = 1'b0;
    logic TRST;
    logic tdo, TMS, TDI;
    int   errors = 0;
    int   checks = 0;

`ifdef JTAG_SEQ_IDLE_PAD_EN
    localparam bit PadEn = 1'b1;
`else
    localparam bit PadEn = 1'b0;
`endif

    jtag_scan_sequencer_if bus ();

    jtag_scan_sequencer dut (
        .TCK (TCK),
        .TRST(TRST),
        .tdo (tdo),
        .TMS (TMS),
        .TDI (TDI),
        .bus (bus)
    );

    always #5 TCK = ~TCK;

    // Reference IEEE 1149.1 TAP; every DR is a 1-bit bypass, IR is 5 bits capturing 5'b00001.
    typedef enum int {
        TapTlr, TapRti, TapSelDr, TapCapDr, TapShDr, TapEx1Dr, TapPauseDr, TapEx2Dr, TapUpdDr,
        TapSelIr, TapCapIr, TapShIr, TapEx1Ir, TapPauseIr, TapEx2Ir, TapUpdIr
    } tap_e;
    tap_e       tap_st = TapShDr;
    logic       byp    = 1'b0;
    logic [4:0] ir_sr  = 5'd0;
    logic [4:0] tap_ir = 5'd0;

    always @(posedge TCK) begin
        case (tap_st)
            TapTlr:     begin tap_ir <= 5'h01; tap_st <= TMS ? TapTlr : TapRti; end
            TapRti:     tap_st <= TMS ? TapSelDr : TapRti;
            TapSelDr:   tap_st <= TMS ? TapSelIr : TapCapDr;
            TapCapDr:   begin byp <= 1'b0; tap_st <= TMS ? TapEx1Dr : TapShDr; end
            TapShDr:    begin byp <= TDI; tap_st <= TMS ? TapEx1Dr : TapShDr; end
            TapEx1Dr:   tap_st <= TMS ? TapUpdDr : TapPauseDr;
            TapPauseDr: tap_st <= TMS ? TapEx2Dr : TapPauseDr;
            TapEx2Dr:   tap_st <= TMS ? TapUpdDr : TapShDr;
            TapUpdDr:   tap_st <= TMS ? TapSelDr : TapRti;
            TapSelIr:   tap_st <= TMS ? TapTlr : TapCapIr;
            TapCapIr:   begin ir_sr <= 5'b00001; tap_st <= TMS ? TapEx1Ir : TapShIr; end
            TapShIr:    begin ir_sr <= {TDI, ir_sr[4:1]}; tap_st <= TMS ? TapEx1Ir : TapShIr; end
            TapEx1Ir:   tap_st <= TMS ? TapUpdIr : TapPauseIr;
            TapPauseIr: tap_st <= TMS ? TapEx2Ir : TapPauseIr;
            TapEx2Ir:   tap_st <= TMS ? TapUpdIr : TapShIr;
            TapUpdIr:   begin tap_ir <= ir_sr; tap_st <= TMS ? TapSelDr : TapRti; end
            default:    tap_st <= TapTlr;
        endcase
    end

    assign tdo = (tap_st == TapShDr) ? byp : (tap_st == TapShIr) ? ir_sr[0] : 1'b0;

    typedef struct {
        logic [63:0] tms;
        logic [63:0] tdi;
        int          ncyc;
        logic [31:0] tdo;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] last_tdo = '0;

    function automatic exp_t make_exp(input logic ir, input int len, input logic [31:0] data,
                                      input int idle);
        exp_t        e;
        int          n, idx, pad;
        logic [36:0] src;
        e.tms = '0; e.tdi = '0; e.err = 1'b0; e.tdo = '0; e.ncyc = 0;
        n = (len > 32) ? 32 : len;
        if (n == 0) begin
            e.err = 1'b1;
            e.tdo = last_tdo;
            return e;
        end
        pad = PadEn ? 1 + idle : 1;
        idx = 0;
        e.tms[idx] = 1'b1; idx++;
        if (ir) begin e.tms[idx] = 1'b1; idx++; end
        idx += 2;
        for (int i = 0; i < n; i++) begin
            e.tms[idx] = (i == n - 1);
            e.tdi[idx] = data[i];
            idx++;
        end
        e.tms[idx] = 1'b1; idx++;
        idx += pad;
        e.ncyc = idx;
        src = ir ? {data, 5'b00001} : {4'b0, data, 1'b0};
        for (int i = 0; i < n; i++) e.tdo[i] = src[i];
        return e;
    endfunction

    // Call at a negedge with busy=0; returns at the negedge on which done is seen.
    task automatic do_scan(input logic ir, input int len, input logic [31:0] data, input int idle,
                           input int poke);
        exp_t        e;
        logic [63:0] tms_s = '0, tdi_s = '0;
        int          cyc = 0;
        bit          seen = 0;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL ready: busy=%b required 0", bus.busy);
        end
        sb_q.push_back(make_exp(ir, len, data, idle));
        bus.start = 1'b1; bus.scan_ir = ir; bus.len = len[5:0];
        bus.tdi_data = data; bus.idle_cnt = idle[3:0];
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge TCK);
            if (bus.done === 1'b1) seen = 1;
            else begin
                if (cyc < 64) begin tms_s[cyc] = TMS; tdi_s[cyc] = TDI; end
                cyc++;
            end
            bus.start = !seen && (k == poke);
            if (bus.start) begin
                bus.len = 6'd0; bus.scan_ir = ~ir; bus.tdi_data = ~data;
            end
        end
        e = sb_q.pop_front();
        checks++;
        if (!seen) begin
            errors++; $display("FAIL done_timeout: no done within 100 cycles");
        end
        checks++;
        if (cyc !== e.ncyc) begin
            errors++; $display("FAIL cycles: got %0d required %0d", cyc, e.ncyc);
        end
        checks++;
        if (tms_s !== e.tms) begin
            errors++; $display("FAIL tms_stream: got %h required %h", tms_s, e.tms);
        end
        checks++;
        if (tdi_s !== e.tdi) begin
            errors++; $display("FAIL tdi_stream: got %h required %h", tdi_s, e.tdi);
        end
        checks++;
        if (bus.err !== e.err) begin
            errors++; $display("FAIL err: got %b required %b", bus.err, e.err);
        end
        checks++;
        if (bus.tdo_data !== e.tdo) begin
            errors++; $display("FAIL tdo_data: got %h required %h", bus.tdo_data, e.tdo);
        end
        checks++;
        if (bus.busy !== 1'b0 || TMS !== 1'b0) begin
            errors++; $display("FAIL finish_pins: busy=%b TMS=%b required 0 0", bus.busy, TMS);
        end
        checks++;
        if (tap_st !== TapRti) begin
            errors++; $display("FAIL tap_rti: tap state %0d required %0d", tap_st, TapRti);
        end
        last_tdo = e.tdo;
    endtask

    task automatic test_reset();
        logic [5:0] tms_s;
        logic [6:0] busy_s;
        TRST = 1'b0; #2; TRST = 1'b1; #1;
        checks++;
        if ({TMS, TDI, bus.busy, bus.done, bus.err} !== 5'b10100) begin
            errors++;
            $display("FAIL reset_pins: TMS,TDI,busy,done,err=%b required 10100",
                     {TMS, TDI, bus.busy, bus.done, bus.err});
        end
        checks++;
        if (bus.tdo_data !== 32'h0) begin
            errors++; $display("FAIL reset_tdo_data: got %h required 0", bus.tdo_data);
        end
        repeat (2) @(negedge TCK);
        TRST = 1'b0;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) @(negedge TCK);
            if (c < 6) tms_s[c] = TMS;
            busy_s[c] = bus.busy;
        end
        checks++;
        if (tms_s !== 6'b011111) begin
            errors++; $display("FAIL sync_tms: got %b required 011111", tms_s);
        end
        checks++;
        if (busy_s !== 7'b0111111) begin
            errors++; $display("FAIL sync_busy: got %b required 0111111", busy_s);
        end
        checks++;
        if (tap_st !== TapRti) begin
            errors++; $display("FAIL sync_tap: tap state %0d required %0d", tap_st, TapRti);
        end
    endtask

    task automatic test_dr_bypass();
        do_scan(1'b0, 8, 32'h0000_00A5, 0, 4);
        checks++;
        if (last_tdo !== 32'h0000_004A) begin
            errors++; $display("FAIL bypass_model: got %h required 4a", last_tdo);
        end
        @(negedge TCK);
    endtask

    task automatic test_ir();
        do_scan(1'b1, 5, 32'h0000_001F, 0, -1);
        checks++;
        if (tap_ir !== 5'h1F) begin
            errors++; $display("FAIL tap_ir: got %h required 1f", tap_ir);
        end
        @(negedge TCK);
    endtask

    task automatic test_reject();
        do_scan(1'b0, 0, 32'hDEAD_BEEF, 0, -1);
        repeat (2) @(negedge TCK);
    endtask

    task automatic test_clamp();
        do_scan(1'b0, 40, $urandom, 0, -1);
        repeat (2) @(negedge TCK);
    endtask

    task automatic test_pad();
        do_scan(1'b0, 4, 32'h0000_0009, 3, -1);
        @(negedge TCK);
    endtask

    task automatic test_back_to_back();
        do_scan(1'b0, 6, 32'h0000_002D, 0, -1);
        do_scan(1'b1, 5, 32'h0000_0013, 0, -1);
        do_scan(1'b0, 0, 32'h0, 0, -1);
        do_scan(1'b0, 1, 32'h0000_0001, 0, -1);
        @(negedge TCK);
    endtask

    task automatic test_stable();
        bit ok = 1;
        do_scan(1'b0, 12, 32'h0000_0C3C, 0, -1);
        bus.tdi_data = 32'hFFFF_FFFF;
        repeat (6) begin
            @(negedge TCK);
            if (bus.tdo_data !== last_tdo) ok = 0;
        end
        checks++;
        if (!ok) begin
            errors++; $display("FAIL tdo_stable: got %h required %h", bus.tdo_data, last_tdo);
        end
    endtask

    task automatic test_trst_abort();
        logic [5:0] tms_s;
        logic [6:0] busy_s;
        bit         idle_ok = 1;
        bus.start = 1'b1; bus.scan_ir = 1'b0; bus.len = 6'd16; bus.tdi_data = 32'h0000_F0F0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge TCK);
            bus.start = 1'b0;
        end
        TRST = 1'b1; #1;
        checks++;
        if ({TMS, TDI, bus.busy, bus.done, bus.err} !== 5'b10100 || bus.tdo_data !== 32'h0) begin
            errors++;
            $display("FAIL abort_pins: TMS,TDI,busy,done,err=%b tdo_data=%h required 10100 0",
                     {TMS, TDI, bus.busy, bus.done, bus.err}, bus.tdo_data);
        end
        last_tdo = '0;
        repeat (2) @(negedge TCK);
        TRST = 1'b0;
        bus.len = 6'd8;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) @(negedge TCK);
            if (c < 6) tms_s[c] = TMS;
            busy_s[c] = bus.busy;
            bus.start = (c >= 1 && c <= 4);
        end
        checks++;
        if (tms_s !== 6'b011111) begin
            errors++; $display("FAIL resync_tms: got %b required 011111", tms_s);
        end
        checks++;
        if (busy_s !== 7'b0111111) begin
            errors++; $display("FAIL resync_busy: got %b required 0111111", busy_s);
        end
        repeat (3) begin
            @(negedge TCK);
            if (TMS !== 1'b0 || bus.busy !== 1'b0) idle_ok = 0;
        end
        checks++;
        if (!idle_ok || tap_st !== TapRti) begin
            errors++;
            $display("FAIL start_ignored: TMS=%b busy=%b tap=%0d required 0 0 %0d",
                     TMS, bus.busy, tap_st, TapRti);
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.scan_ir = 1'b0; bus.len = 6'd0;
        bus.tdi_data = '0; bus.idle_cnt = 4'd0;
        test_reset();
        @(negedge TCK);
        test_dr_bypass();
        test_ir();
        test_reject();
        test_clamp();
        test_pad();
        test_back_to_back();
        test_stable();
        test_trst_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/jtag_scan_sequencer.md
JTAG_SCAN_SEQUENCER -- requirements
Module: jtag_scan_sequencer

Interface
REQ-001 SHALL have port TCK, input, 1, sole clock; all state updates on posedge TCK.
REQ-002 SHALL have port TRST, input, 1, reset, asynchronous, active-high.
REQ-003 SHALL have port start, input, 1, one-cycle scan request, sampled only when busy=0.
REQ-004 SHALL have port scan_ir, input, 1, 1 = IR scan, 0 = DR scan, captured with start.
REQ-005 SHALL have port len, input, 6, scan length in bits, captured with start.
REQ-006 SHALL have port tdi_data, input, 32, shift-in data, LSB shifted first, captured with start.
REQ-007 SHALL have port tdo, input, 1, serial data returned from target TAP.
REQ-008 SHALL have port idle_cnt, input, 4, extra Run-Test/Idle cycles, used only under JTAG_SEQ_IDLE_PAD_EN.
REQ-009 SHALL have port TMS, output, 1, registered TMS to target TAP.
REQ-010 SHALL have port TDI, output, 1, registered TDI to target TAP.
REQ-011 SHALL have port busy, output, 1, sequence in progress.
REQ-012 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-013 SHALL have port err, output, 1, valid with done; 1 = request rejected.
REQ-014 SHALL have port tdo_data, output, 32, captured TDO bits, right-justified, bit0 = first sampled.

Function
REQ-015 SHALL implement states SYNC, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, PAD, FINISH.
REQ-016 SYNC SHALL drive TMS=1 for 5 cycles then TMS=0 for 1 cycle, then enter IDLE; busy=1 throughout.
REQ-017 IDLE SHALL drive TMS=0, TDI=0, busy=0; start=1 latches scan_ir, len, tdi_data and enters SEL_DR next cycle.
REQ-018 TMS per cycle: SEL_DR 1, SEL_IR 1 (IR only), CAPTURE 0, CAPTURE-to-shift 0, SHIFT 0 for bits 0..N-2, 1 for bit N-1, UPDATE 1, return 0.
REQ-019 Resulting TMS stream: DR scan 1,0,0,{0 x N-1},1,1,0 (N+5 cycles); IR scan 1,1,0,0,{0 x N-1},1,1,0 (N+6 cycles).
REQ-020 TDI SHALL present tdi_data[i] during the cycle carrying shift bit i; TDI=0 outside shift cycles.
REQ-021 tdo SHALL be sampled at the posedge ending each shift cycle; sample i written to tdo_data[i]; bits >= N cleared to 0.
REQ-022 Bit counter 5-bit, counts 0..N-1, no wrap beyond N-1.
REQ-023 len=0 SHALL be rejected: no TMS activity, done=1 and err=1 on the cycle after start, tdo_data unchanged.
REQ-024 len>32 SHALL be clamped to 32; err=0.
REQ-025 done SHALL pulse for exactly one cycle in FINISH, i.e. the cycle after the final TMS=0 return cycle; busy deasserts in the same cycle.
REQ-026 start while busy=1 SHALL be ignored, with no queuing.
REQ-027 tdo_data SHALL be stable from done until the next accepted start.

Reset
REQ-028 TRST=1 SHALL immediately force TMS=1, TDI=0, busy=1, done=0, err=0, tdo_data=0, state=SYNC, counters=0.
REQ-029 TRST asserted mid-scan SHALL abort the scan; after release, SYNC re-walks the target to Run-Test/Idle before any start is accepted.

Configuration
REQ-030 Macro JTAG_SEQ_IDLE_PAD_EN defined: after UPDATE, the block SHALL hold TMS=0 for 1+idle_cnt cycles (PAD) before FINISH; idle_cnt is sampled at start.
REQ-031 Macro JTAG_SEQ_IDLE_PAD_EN undefined: idle_cnt SHALL be ignored and the block SHALL hold exactly 1 TMS=0 return cycle; the PAD counter is not built.

Verification
REQ-032 Release TRST -> TMS = 1,1,1,1,1,0, busy falls on the 7th cycle; a reference TAP model reaches Run-Test/Idle.
REQ-033 DR scan, len=8, tdi_data=0xA5, TAP model in BYPASS with tdo looped through 1 flop -> TMS = 1,0,0,0x7,1,1,0; TDI = 1,0,1,0,0,1,0,1; tdo_data = 0x4A with bit0 = bypass capture 0; done after 13 cycles.
REQ-034 IR scan, len=5, tdi_data=0x1F -> TMS = 1,1,0,0,0,0,0,0,1,1,0; TAP model IR = 0x1F; tdo_data[1:0] = 2'b01 (IR capture).
REQ-035 len=0 -> done=1, err=1 next cycle, TMS held 0; len=40 -> 32-bit scan, err=0.
REQ-036 TRST pulsed during shift bit 3 of a 16-bit scan -> TMS=1 immediately, SYNC sequence replayed, start ignored until busy=0.
REQ-037 JTAG_SEQ_IDLE_PAD_EN, idle_cnt=3, DR len=4 -> 4 TMS=0 cycles after UPDATE, done after 12 cycles; same stimulus without macro -> done after 9 cycles.
